// File: rtl/arm_multicycle.sv
// Multicycle ARMv4-subset core (ADD/SUB/AND/ORR, LDR/STR, B) over one ALU and one shared memory port.
// Define ARM_MULTI_BL_EN to make bit 24 of a branch (BL) also write the return address into R14.
module arm_multicycle #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned WAIT_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        MemReq,
    output logic        MemWrite,
    output logic [31:0] MemAdr,
    output logic [31:0] MemWriteData,
    input  logic        MemReady,
    input  logic [31:0] MemReadData,
    output logic        Fault,
    output logic [3:0]  state_dbg
);
    // Memory handshake: MemReq/MemWrite/MemAdr/MemWriteData stay stable until the rising edge
    // with MemReq=1 and MemReady=1, which completes the transfer; MemReady is ignored while MemReq=0.

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXECR    = 4'd2,
        S_EXECI    = 4'd3,
        S_ALUWB    = 4'd4,
        S_MEMADR   = 4'd5,
        S_MEMREAD  = 4'd6,
        S_MEMWB    = 4'd7,
        S_MEMWRITE = 4'd8,
        S_BRANCH   = 4'd9
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_ORR = 2'd3
    } alu_op_t;

    state_t      state, state_next;
    logic [31:0] pc, ir, data, a, wd, aluout;
    logic [31:0] rf [15];
    logic [3:0]  nzcv;
    logic        fault;
    logic [31:0] wait_cnt;

    logic [3:0]  cond, funct, rn, rd, rm, rb_sel;
    logic [1:0]  op;
    logic        imm_i, set_s, is_load, is_bl, dp_ok, cond_pass;
    logic [31:0] r15, rd_a, rd_b;

    assign cond    = ir[31:28];
    assign op      = ir[27:26];
    assign imm_i   = ir[25];
    assign funct   = ir[24:21];
    assign set_s   = ir[20];
    assign is_load = ir[20];
    assign rn      = ir[19:16];
    assign rd      = ir[15:12];
    assign rm      = ir[3:0];
    assign dp_ok   = (funct == 4'b0000) || (funct == 4'b0010) ||
                     (funct == 4'b0100) || (funct == 4'b1100);
`ifdef ARM_MULTI_BL_EN
    assign is_bl = ir[24];
`else
    assign is_bl = 1'b0;
`endif

    // pc already holds instruction address + 4 after FETCH, so R15 reads pc + 4.
    assign r15    = pc + 32'd4;
    assign rb_sel = (op == 2'b01) ? rd : rm;

    always_comb begin
        rd_a = r15;
        rd_b = r15;
        for (int k = 0; k < 15; k++) begin
            if (rn == 4'(k))     rd_a = rf[k];
            if (rb_sel == 4'(k)) rd_b = rf[k];
        end
    end

    always_comb begin
        cond_pass = 1'b1;
        case (cond)
            4'h0:    cond_pass = nzcv[2];
            4'h1:    cond_pass = !nzcv[2];
            4'h2:    cond_pass = nzcv[1];
            4'h3:    cond_pass = !nzcv[1];
            4'h4:    cond_pass = nzcv[3];
            4'h5:    cond_pass = !nzcv[3];
            4'h6:    cond_pass = nzcv[0];
            4'h7:    cond_pass = !nzcv[0];
            4'h8:    cond_pass = nzcv[1] && !nzcv[2];
            4'h9:    cond_pass = !nzcv[1] || nzcv[2];
            4'hA:    cond_pass = (nzcv[3] == nzcv[0]);
            4'hB:    cond_pass = (nzcv[3] != nzcv[0]);
            4'hC:    cond_pass = !nzcv[2] && (nzcv[3] == nzcv[0]);
            4'hD:    cond_pass = nzcv[2] || (nzcv[3] != nzcv[0]);
            default: cond_pass = 1'b1;
        endcase
    end

    // Single shared ALU; operand muxing depends on the sequencing state.
    alu_op_t     alu_op;
    logic [31:0] alu_a, alu_b, alu_b_eff, alu_res;
    logic [32:0] alu_sum;
    logic        alu_sub, alu_v;

    always_comb begin
        alu_a  = a;
        alu_b  = wd;
        alu_op = ALU_ADD;
        case (state)
            S_EXECR, S_EXECI: begin
                alu_b = (state == S_EXECI) ? {24'd0, ir[7:0]} : wd;
                case (funct)
                    4'b0000: alu_op = ALU_AND;
                    4'b0010: alu_op = ALU_SUB;
                    4'b1100: alu_op = ALU_ORR;
                    default: alu_op = ALU_ADD;
                endcase
            end
            S_MEMADR: alu_b = {20'd0, ir[11:0]};
            S_BRANCH: begin
                alu_a = r15;
                alu_b = {{6{ir[23]}}, ir[23:0], 2'b00};
            end
            default: ;
        endcase
    end

    assign alu_sub   = (alu_op == ALU_SUB);
    assign alu_b_eff = alu_sub ? ~alu_b : alu_b;
    assign alu_sum   = {1'b0, alu_a} + {1'b0, alu_b_eff} + {32'd0, alu_sub};
    assign alu_v     = (alu_a[31] == alu_b_eff[31]) && (alu_sum[31] != alu_a[31]);

    always_comb begin
        alu_res = alu_sum[31:0];
        case (alu_op)
            ALU_AND: alu_res = alu_a & alu_b;
            ALU_ORR: alu_res = alu_a | alu_b;
            default: alu_res = alu_sum[31:0];
        endcase
    end

    logic        mem_req, mem_write, mem_wait, mem_done, timeout;
    logic [31:0] mem_adr, rdata;

    always_comb begin
        mem_req   = 1'b0;
        mem_write = 1'b0;
        mem_adr   = pc;
        case (state)
            S_FETCH:   mem_req = 1'b1;
            S_MEMREAD: begin
                mem_req = 1'b1;
                mem_adr = aluout;
            end
            S_MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                mem_adr   = aluout;
            end
            default: ;
        endcase
    end

    // An abandoned (timed-out) transfer completes like a normal one but reads as zero.
    assign mem_wait = mem_req && !MemReady;
    assign timeout  = (WAIT_TIMEOUT != 0) && mem_wait && (wait_cnt == WAIT_TIMEOUT - 1);
    assign mem_done = mem_req && (MemReady || timeout);
    assign rdata    = MemReady ? MemReadData : 32'd0;

    assign MemReq       = mem_req && !reset;
    assign MemWrite     = mem_write && !reset;
    assign MemAdr       = mem_adr;
    assign MemWriteData = wd;
    assign Fault        = fault;
    assign state_dbg    = state;

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:  if (mem_done) state_next = S_DECODE;
            S_DECODE: begin
                if (!cond_pass) state_next = S_FETCH;
                else begin
                    case (op)
                        2'b00:   state_next = !dp_ok ? S_FETCH : (imm_i ? S_EXECI : S_EXECR);
                        2'b01:   state_next = S_MEMADR;
                        2'b10:   state_next = S_BRANCH;
                        default: state_next = S_FETCH;
                    endcase
                end
            end
            S_EXECR, S_EXECI: state_next = S_ALUWB;
            S_MEMADR:   state_next = is_load ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (mem_done) state_next = S_MEMWB;
            S_MEMWRITE: if (mem_done) state_next = S_FETCH;
            default:    state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= RESET_PC;
            ir       <= 32'd0;
            data     <= 32'd0;
            a        <= 32'd0;
            wd       <= 32'd0;
            aluout   <= 32'd0;
            nzcv     <= 4'd0;
            fault    <= 1'b0;
            wait_cnt <= 32'd0;
        end else begin
            wait_cnt <= (mem_wait && !timeout) ? wait_cnt + 32'd1 : 32'd0;
            if (timeout) fault <= 1'b1;
            case (state)
                S_FETCH: if (mem_done) begin
                    ir <= rdata;
                    pc <= r15;
                end
                S_DECODE: begin
                    a  <= rd_a;
                    wd <= rd_b;
                    if (cond_pass && ((op == 2'b11) || ((op == 2'b00) && !dp_ok))) fault <= 1'b1;
                end
                S_EXECR, S_EXECI: begin
                    aluout <= alu_res;
                    if (set_s) begin
                        nzcv[3] <= alu_res[31];
                        nzcv[2] <= (alu_res == 32'd0);
                        if ((alu_op == ALU_ADD) || (alu_op == ALU_SUB)) begin
                            nzcv[1] <= alu_sum[32];
                            nzcv[0] <= alu_v;
                        end
                    end
                end
                S_ALUWB:   if (rd == 4'hF) pc <= aluout;
                S_MEMADR:  aluout <= alu_res;
                S_MEMREAD: if (mem_done) data <= rdata;
                S_MEMWB:   if (rd == 4'hF) pc <= data;
                S_BRANCH:  pc <= alu_res;
                default: ;
            endcase
        end
    end

    logic        rf_we;
    logic [3:0]  rf_wa;
    logic [31:0] rf_wd;

    always_comb begin
        rf_we = 1'b0;
        rf_wa = rd;
        rf_wd = aluout;
        case (state)
            S_ALUWB: rf_we = (rd != 4'hF);
            S_MEMWB: begin
                rf_we = (rd != 4'hF);
                rf_wd = data;
            end
            S_BRANCH: if (is_bl) begin
                rf_we = 1'b1;
                rf_wa = 4'd14;
                rf_wd = pc;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset && rf_we) begin
            for (int k = 0; k < 15; k++) begin
                if (rf_wa == 4'(k)) rf[k] <= rf_wd;
            end
        end
    end

endmodule

// File: tb/tb_arm_multicycle.sv
// Directed bench for arm_multicycle: small program in a ROM model, stall/timeout memory responder,
// write scoreboard and cycle-count checks; RESET_PC=0x40, WAIT_TIMEOUT=8.
module tb_arm_multicycle;
    localparam logic [31:0] RST_PC = 32'h0000_0040;
`ifdef ARM_MULTI_BL_EN
    localparam logic [31:0] EXP_R14 = 32'h0000_0094;
`else
    localparam logic [31:0] EXP_R14 = 32'h0000_0033;
`endif
    localparam logic [3:0] ST_FETCH = 4'd0, ST_DECODE = 4'd1, ST_MEMWRITE = 4'd8;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemReq, MemWrite, MemReady, Fault;
    logic [31:0] MemAdr, MemWriteData, MemReadData;
    logic [3:0]  state_dbg;

    always #5 clk = ~clk;

    arm_multicycle #(.RESET_PC(RST_PC), .WAIT_TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .MemReq(MemReq), .MemWrite(MemWrite), .MemAdr(MemAdr),
        .MemWriteData(MemWriteData), .MemReady(MemReady), .MemReadData(MemReadData),
        .Fault(Fault), .state_dbg(state_dbg)
    );

    // Memory model: program ROM per phase, data overlay written by stores.
    int          phase = 1;
    int          stall_wr = 3;
    int          wait_ctr = 0;
    int          wr_count = 0;
    int          cyc = 0;
    logic [31:0] dmem [256];
    bit          dvalid [256];
    logic [63:0] exp_q[$];
    logic [63:0] act_q[$];

    function automatic logic [31:0] rom(input logic [31:0] adr, input int ph);
        logic [31:0] w;
        w = 32'h0;
        if (ph == 1) begin
            case (adr)
                32'h40: w = 32'hE04F000F; // SUB  R0,R15,R15
                32'h44: w = 32'hE2802005; // ADD  R2,R0,#5
                32'h48: w = 32'hE3823002; // ORR  R3,R2,#2
                32'h4C: w = 32'hE2805055; // ADD  R5,R0,#0x55
                32'h50: w = 32'hE5803064; // STR  R3,[R0,#100]
                32'h54: w = 32'hE0521002; // SUBS R1,R2,R2
                32'h58: w = 32'h02804001; // ADDEQ R4,R0,#1
                32'h5C: w = 32'h12805001; // ADDNE R5,R0,#1
                32'h60: w = 32'hEA000006; // B 0x80
                32'h80: w = 32'hE2806009; // ADD  R6,R0,#9
                32'h84: w = 32'hE280E033; // ADD  R14,R0,#0x33
                32'h88: w = 32'hE5907064; // LDR  R7,[R0,#0x64]
                32'h8C: w = 32'hE59060F0; // LDR  R6,[R0,#0xF0] (never ready)
                32'h90: w = 32'hEB000002; // BL 0xA0
                32'hA0: w = 32'hEAFFFFFE; // B .
                default: w = 32'h0;
            endcase
        end else begin
            case (adr)
                32'h40: w = 32'hEC000000; // op 11: unimplemented
                32'h44: w = 32'hE5803068; // STR R3,[R0,#0x68]
                default: w = 32'h0;
            endcase
        end
        return w;
    endfunction

    assign MemReadData = dvalid[MemAdr[9:2]] ? dmem[MemAdr[9:2]] : rom(MemAdr, phase);
    assign MemReady    = (!MemWrite && MemAdr == 32'hF0) ? 1'b0 :
                         (MemWrite ? (wait_ctr >= stall_wr) : 1'b1);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (MemReq && !MemReady) wait_ctr <= wait_ctr + 1;
        else                     wait_ctr <= 0;
        if (MemReq && MemWrite && MemReady) begin
            dmem[MemAdr[9:2]]   <= MemWriteData;
            dvalid[MemAdr[9:2]] <= 1'b1;
            wr_count            <= wr_count + 1;
            act_q.push_back({MemAdr, MemWriteData});
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_fetch(input logic [31:0] adr, output int c);
        bit found;
        found = 1'b0;
        c = -1;
        for (int i = 0; i < 200 && !found; i++) begin
            if (state_dbg == ST_FETCH && MemReq && MemAdr == adr) begin
                found = 1'b1;
                c = cyc;
            end else begin
                step();
            end
        end
        check($sformatf("fetch_%0h_seen", adr), 32'(found), 32'd1);
    endtask

    initial begin
        int c40, c44, c48, c4c, c50, c54, c58, c5c, c60, c80, c84, c88, c8c, c90, ca0, cl1, cl2;
        logic [63:0] e, g;

        reset = 1'b1;
        repeat (3) @(posedge clk);
        step();
        check("rst_state", 32'(state_dbg), 32'(ST_FETCH));
        check("rst_pc", dut.pc, RST_PC);
        check("rst_ir", dut.ir, 32'h0);
        check("rst_flags", 32'(dut.nzcv), 32'h0);
        check("rst_fault", 32'(Fault), 32'h0);
        check("rst_memreq", 32'(MemReq), 32'h0);

        reset = 1'b0;
        #1;
        check("first_req", 32'(MemReq), 32'h1);
        check("first_adr", MemAdr, 32'h40);
        check("first_rd", 32'(MemWrite), 32'h0);
        wait_fetch(32'h40, c40);
        step();
        check("ir_load", dut.ir, 32'hE04F000F);
        check("pc_plus4", dut.pc, 32'h44);
        check("decode_state", 32'(state_dbg), 32'(ST_DECODE));

        wait_fetch(32'h44, c44);
        check("cpi_sub", 32'(c44 - c40), 32'd4);
        check("r0_zero", dut.rf[0], 32'h0);
        wait_fetch(32'h48, c48);
        check("cpi_add", 32'(c48 - c44), 32'd4);
        check("r2", dut.rf[2], 32'h5);
        wait_fetch(32'h4C, c4c);
        check("cpi_orr", 32'(c4c - c48), 32'd4);
        check("r3_orr", dut.rf[3], 32'h7);
        wait_fetch(32'h50, c50);
        check("r5_init", dut.rf[5], 32'h55);

        exp_q.push_back({32'h64, 32'h7});
        step();
        step();
        step();
        for (int i = 0; i < 4; i++) begin
            check("str_state", 32'(state_dbg), 32'(ST_MEMWRITE));
            check("str_req", 32'(MemReq), 32'h1);
            check("str_we", 32'(MemWrite), 32'h1);
            check("str_adr", MemAdr, 32'h64);
            check("str_wdata", MemWriteData, 32'h7);
            check("str_pending", 32'(wr_count), 32'd0);
            if (i < 3) step();
        end
        wait_fetch(32'h54, c54);
        check("str_latency", 32'(c54 - c50), 32'd7);
        check("str_count", 32'(wr_count), 32'd1);

        wait_fetch(32'h58, c58);
        check("cpi_subs", 32'(c58 - c54), 32'd4);
        check("subs_flags", 32'(dut.nzcv), 32'h6);
        check("r1_zero", dut.rf[1], 32'h0);
        wait_fetch(32'h5C, c5c);
        check("addeq_r4", dut.rf[4], 32'h1);
        wait_fetch(32'h60, c60);
        check("addne_cycles", 32'(c60 - c5c), 32'd2);
        check("addne_r5", dut.rf[5], 32'h55);
        wait_fetch(32'h80, c80);
        check("b_cycles", 32'(c80 - c60), 32'd3);

        wait_fetch(32'h84, c84);
        wait_fetch(32'h88, c88);
        check("r6_pre", dut.rf[6], 32'h9);
        wait_fetch(32'h8C, c8c);
        check("ldr_cycles", 32'(c8c - c88), 32'd5);
        check("ldr_r7", dut.rf[7], 32'h7);
        check("fault_pre", 32'(Fault), 32'h0);
        wait_fetch(32'h90, c90);
        check("tmo_cycles", 32'(c90 - c8c), 32'd12);
        check("tmo_fault", 32'(Fault), 32'h1);
        check("tmo_r6", dut.rf[6], 32'h0);

        wait_fetch(32'hA0, ca0);
        check("bl_cycles", 32'(ca0 - c90), 32'd3);
        check("bl_r14", dut.rf[14], EXP_R14);
        step();
        wait_fetch(32'hA0, cl1);
        check("loop_1", 32'(cl1 - ca0), 32'd3);
        step();
        wait_fetch(32'hA0, cl2);
        check("loop_2", 32'(cl2 - cl1), 32'd3);

        reset = 1'b1;
        #1;
        check("rst_gate_req", 32'(MemReq), 32'h0);
        step();
        check("rst2_state", 32'(state_dbg), 32'(ST_FETCH));
        check("rst2_pc", dut.pc, RST_PC);
        check("rst2_fault", 32'(Fault), 32'h0);
        check("rst2_flags", 32'(dut.nzcv), 32'h0);
        phase = 2;
        reset = 1'b0;
        #1;
        wait_fetch(32'h40, c40);
        wait_fetch(32'h44, c44);
        check("op11_cycles", 32'(c44 - c40), 32'd2);
        check("op11_fault", 32'(Fault), 32'h1);
        step();
        step();
        step();
        check("str2_req", 32'(MemReq), 32'h1);
        check("str2_adr", MemAdr, 32'h68);
        step();
        reset = 1'b1;
        #1;
        check("mid_rst_req", 32'(MemReq), 32'h0);
        check("mid_rst_we", 32'(MemWrite), 32'h0);
        step();
        check("mid_rst_state", 32'(state_dbg), 32'(ST_FETCH));
        check("mid_rst_nowrite", 32'(wr_count), 32'd1);
        check("mid_rst_fault", 32'(Fault), 32'h0);
        reset = 1'b0;
        #1;
        check("post_rst_req", 32'(MemReq), 32'h1);
        check("post_rst_adr", MemAdr, 32'h40);

        check("sb_count", 32'(act_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && act_q.size() > 0) begin
            e = exp_q.pop_front();
            g = act_q.pop_front();
            check("sb_adr", g[63:32], e[63:32]);
            check("sb_data", g[31:0], e[31:0]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
